// File: rtl/axis_dwidth_downsizer.sv
// Wide-to-narrow AXI-Stream converter: one WIDTH*NUM_REG-bit word in, up to NUM_REG
// WIDTH-bit beats out, most-significant kept lane first, with a one-word holding buffer.
module axis_dwidth_downsizer #(
  parameter int WIDTH   = 32,
  parameter int NUM_REG = 2
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic [WIDTH*NUM_REG-1:0] s_axis_tdata,
  input  logic [NUM_REG-1:0]       s_axis_tkeep,
  input  logic                     s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic                     m_axis_tlast
);

  localparam int IDX_W = (NUM_REG > 1) ? $clog2(NUM_REG) : 1;

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_SEND  = 1'b1;

  logic [0:0]               state_q, state_d;
  logic [WIDTH*NUM_REG-1:0] buf_q, buf_d;
  logic [NUM_REG-1:0]       rem_q, rem_d;
  logic                     word_last_q, word_last_d;
  logic [WIDTH-1:0]         tdata_q, tdata_d;
  logic                     tlast_q, tlast_d;

  logic                     s_ready_s;
  logic                     s_fire_s;
  logic                     m_fire_s;
  logic                     final_beat_s;
  logic                     load_s;
  logic [NUM_REG-1:0]       eff_keep_s;
  logic [NUM_REG-1:0]       src_mask_s;
  logic [NUM_REG-1:0]       next_rem_s;
  logic [WIDTH*NUM_REG-1:0] src_data_s;
  logic                     src_last_s;
  logic [IDX_W-1:0]         lane_s;

  function automatic logic [IDX_W-1:0] top_lane(input logic [NUM_REG-1:0] mask);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (mask[i]) begin
        idx = IDX_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  function automatic logic [NUM_REG-1:0] clear_lane(input logic [NUM_REG-1:0] mask,
                                                    input logic [IDX_W-1:0] idx);
    logic [NUM_REG-1:0] m;
    m = mask;
    for (int i = 0; i < NUM_REG; i++) begin
      if (idx == IDX_W'(i)) begin
        m[i] = 1'b0;
      end else begin
        m[i] = m[i];
      end
    end
    return m;
  endfunction

  function automatic logic [WIDTH-1:0] lane_data(input logic [WIDTH*NUM_REG-1:0] data,
                                                 input logic [IDX_W-1:0] idx);
    logic [WIDTH-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (idx == IDX_W'(i)) begin
        d = data[i*WIDTH +: WIDTH];
      end else begin
        d = d;
      end
    end
    return d;
  endfunction

  // Handshake qualification and upstream ready (never a function of s_axis_tvalid)
  always_comb begin
    m_fire_s     = (state_q == ST_SEND) && m_axis_tready;
    final_beat_s = m_fire_s && (rem_q == '0);
    case (state_q)
      ST_EMPTY: s_ready_s = ~areset;
      ST_SEND:  s_ready_s = ~areset & final_beat_s;
      default:  s_ready_s = 1'b0;
    endcase
    s_fire_s   = s_ready_s && s_axis_tvalid;
    eff_keep_s = s_axis_tkeep;
    // An all-zero keep on a packet end still needs one beat to carry tlast.
    if ((s_axis_tkeep == '0) && s_axis_tlast) begin
      eff_keep_s[NUM_REG-1] = 1'b1;
    end else begin
      eff_keep_s = s_axis_tkeep;
    end
  end

  // Next-state: pick the next lane either from a fresh word or from the held remainder
  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    rem_d       = rem_q;
    word_last_d = word_last_q;
    tdata_d     = tdata_q;
    tlast_d     = tlast_q;
    src_mask_s  = '0;
    src_data_s  = buf_q;
    src_last_s  = word_last_q;
    load_s      = 1'b0;
    if (s_fire_s) begin
      src_mask_s  = eff_keep_s;
      src_data_s  = s_axis_tdata;
      src_last_s  = s_axis_tlast;
      buf_d       = s_axis_tdata;
      word_last_d = s_axis_tlast;
      load_s      = 1'b1;
    end else if (m_fire_s) begin
      src_mask_s = rem_q;
      load_s     = 1'b1;
    end else begin
      load_s = 1'b0;
    end
    lane_s     = top_lane(src_mask_s);
    next_rem_s = clear_lane(src_mask_s, lane_s);
    if (load_s) begin
      if (src_mask_s != '0) begin
        state_d = ST_SEND;
        tdata_d = lane_data(src_data_s, lane_s);
        tlast_d = src_last_s && (next_rem_s == '0);
        rem_d   = next_rem_s;
      end else begin
        state_d = ST_EMPTY;
        tlast_d = 1'b0;
        rem_d   = '0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_EMPTY;
      buf_q       <= '0;
      rem_q       <= '0;
      word_last_q <= 1'b0;
      tdata_q     <= '0;
      tlast_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      rem_q       <= rem_d;
      word_last_q <= word_last_d;
      tdata_q     <= tdata_d;
      tlast_q     <= tlast_d;
    end
  end

  assign s_axis_tready = s_ready_s;
  assign m_axis_tvalid = (state_q == ST_SEND);
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_dwidth_downsizer.sv
// Self-checking bench for axis_dwidth_downsizer: directed literal cases plus randomized
// traffic compared every cycle against a queue-of-expected-beats model.
module tb_axis_dwidth_downsizer;

  localparam int W  = 32;
  localparam int N  = 2;
  localparam int DW = W * N;

  logic          aclk;
  logic          areset;
  logic          s_tvalid;
  logic          s_tready;
  logic [DW-1:0] s_tdata;
  logic [N-1:0]  s_tkeep;
  logic          s_tlast;
  logic          m_tvalid;
  logic          m_tready;
  logic [W-1:0]  m_tdata;
  logic          m_tlast;

  typedef struct {
    logic [W-1:0] d;
    logic         l;
  } beat_t;

  beat_t        exp_q[$];
  logic [W-1:0] obs_d[$];
  logic         obs_l[$];
  int           obs_c[$];
  int           acc_c[$];

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic mon_en   = 1'b0;
  logic rnd_done = 1'b0;

  axis_dwidth_downsizer #(.WIDTH(W), .NUM_REG(N)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tkeep  (s_tkeep),
    .s_axis_tlast  (s_tlast),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_bound(input string name);
    checks++;
    failures++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // Expected beats of one accepted word: kept lanes from the top down, tlast on the lowest kept lane.
  task automatic push_word(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
    logic [N-1:0] ek;
    int lo;
    ek = k;
    if (k == '0 && l) ek[N-1] = 1'b1;
    lo = -1;
    for (int j = 0; j < N; j++) if (ek[j] && lo < 0) lo = j;
    for (int j = N - 1; j >= 0; j--)
      if (ek[j]) exp_q.push_back('{d[j*W +: W], l && (j == lo)});
  endtask

  always @(negedge aclk) begin
    logic exp_sr;
    if (mon_en) begin
      chk("m_tvalid", {63'd0, m_tvalid}, {63'd0, exp_q.size() != 0});
      exp_sr = !areset && (exp_q.size() == 0 || (exp_q.size() == 1 && m_tready));
      chk("s_tready", {63'd0, s_tready}, {63'd0, exp_sr});
      if (m_tvalid && exp_q.size() != 0) begin
        chk("m_tdata", {32'd0, m_tdata}, {32'd0, exp_q[0].d});
        chk("m_tlast", {63'd0, m_tlast}, {63'd0, exp_q[0].l});
      end
      if (m_tvalid && m_tready) begin
        obs_d.push_back(m_tdata);
        obs_l.push_back(m_tlast);
        obs_c.push_back(cyc);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      if (s_tvalid && s_tready) begin
        acc_c.push_back(cyc);
        push_word(s_tdata, s_tkeep, s_tlast);
      end
      if (areset) exp_q.delete();
    end
  end

  task automatic clear_logs();
    obs_d.delete(); obs_l.delete(); obs_c.delete(); acc_c.delete();
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic [N-1:0] k, input logic l);
    logic hs;
    int t;
    s_tvalid = 1'b1; s_tdata = d; s_tkeep = k; s_tlast = l;
    t = 0;
    hs = 1'b0;
    do begin
      @(negedge aclk);
      hs = s_tready;
      @(posedge aclk);
      #1;
      t++;
    end while (!hs && t < 200);
    if (!hs) fail_bound("send_word");
    s_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge aclk);
      #1;
      t++;
    end
    if (exp_q.size() != 0) fail_bound("wait_idle");
  endtask

  task automatic chk_beat(input string name, input int i, input logic [W-1:0] d, input logic l);
    if (obs_d.size() > i) begin
      chk({name, "_data"}, {32'd0, obs_d[i]}, {32'd0, d});
      chk({name, "_last"}, {63'd0, obs_l[i]}, {63'd0, l});
    end else begin
      fail_bound({name, "_missing"});
    end
  endtask

  initial begin
    int c0;
    logic [DW-1:0] rd;
    logic [N-1:0]  rk;
    logic          rl;
    areset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; m_tready = 1'b0;
    @(posedge aclk); #1; mon_en = 1'b1;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
    chk("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
    @(posedge aclk); #1; areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_s_tready", {63'd0, s_tready}, 64'd1);
    @(posedge aclk); #1;

    // Test 1: single full word, latency and order
    clear_logs(); m_tready = 1'b1;
    send_word(64'hAAAA_AAAA_BBBB_BBBB, 2'b11, 1'b1);
    wait_idle();
    chk("t1_count", obs_d.size(), 64'd2);
    chk_beat("t1_b0", 0, 32'hAAAA_AAAA, 1'b0);
    chk_beat("t1_b1", 1, 32'hBBBB_BBBB, 1'b1);
    if (obs_c.size() == 2 && acc_c.size() == 1) begin
      chk("t1_lat0", obs_c[0] - acc_c[0], 64'd1);
      chk("t1_lat1", obs_c[1] - acc_c[0], 64'd2);
    end else fail_bound("t1_timing");

    // Test 2: three full words back-to-back, no output gaps
    clear_logs();
    send_word(64'h0000_0001_0000_0002, 2'b11, 1'b0);
    send_word(64'h0000_0003_0000_0004, 2'b11, 1'b0);
    send_word(64'h0000_0005_0000_0006, 2'b11, 1'b1);
    wait_idle();
    chk("t2_count", obs_d.size(), 64'd6);
    for (int i = 0; i < 6; i++) chk_beat("t2_b", i, W'(i + 1), i == 5);
    if (obs_c.size() == 6) chk("t2_span", obs_c[5] - obs_c[0], 64'd5);
    else fail_bound("t2_span");

    // Test 3: padded lane dropped
    clear_logs();
    send_word(64'h1111_1111_0000_0000, 2'b10, 1'b1);
    wait_idle();
    chk("t3_count", obs_d.size(), 64'd1);
    chk_beat("t3_b0", 0, 32'h1111_1111, 1'b1);

    // Test 4: stalls 0,0,1,0,1
    clear_logs(); m_tready = 1'b0;
    send_word(64'hCAFE_0001_CAFE_0002, 2'b11, 1'b1);
    c0 = acc_c.size() > 0 ? acc_c[0] : 0;
    m_tready = 1'b0; @(posedge aclk); #1;
    m_tready = 1'b0; @(posedge aclk); #1;
    m_tready = 1'b1; @(posedge aclk); #1;
    m_tready = 1'b0; @(posedge aclk); #1;
    m_tready = 1'b1; @(posedge aclk); #1;
    m_tready = 1'b1;
    wait_idle();
    chk("t4_count", obs_d.size(), 64'd2);
    chk_beat("t4_b0", 0, 32'hCAFE_0001, 1'b0);
    chk_beat("t4_b1", 1, 32'hCAFE_0002, 1'b1);
    if (obs_c.size() == 2) begin
      chk("t4_cyc0", obs_c[0] - c0, 64'd3);
      chk("t4_cyc1", obs_c[1] - c0, 64'd5);
    end else fail_bound("t4_timing");

    // Test 5: zero-keep words
    clear_logs();
    send_word(64'h5555_5555_6666_6666, 2'b00, 1'b0);
    repeat (3) @(posedge aclk);
    #1;
    chk("t5_drop_count", obs_d.size(), 64'd0);
    send_word(64'h7777_7777_8888_8888, 2'b00, 1'b1);
    wait_idle();
    chk("t5_count", obs_d.size(), 64'd1);
    chk_beat("t5_b0", 0, 32'h7777_7777, 1'b1);

    // Test 6: reset mid-packet
    clear_logs();
    send_word(64'h9999_9999_4444_4444, 2'b11, 1'b1);
    @(posedge aclk); #1;
    areset = 1'b1; m_tready = 1'b0;
    @(posedge aclk);
    @(negedge aclk);
    chk("t6_rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("t6_rst_s_tready", {63'd0, s_tready}, 64'd0);
    @(posedge aclk); #1; areset = 1'b0;
    @(negedge aclk);
    chk("t6_s_tready", {63'd0, s_tready}, 64'd1);
    @(posedge aclk); #1;
    clear_logs(); m_tready = 1'b1;
    send_word(64'h2222_2222_3333_3333, 2'b11, 1'b1);
    wait_idle();
    chk("t6_count", obs_d.size(), 64'd2);
    chk_beat("t6_b0", 0, 32'h2222_2222, 1'b0);
    chk_beat("t6_b1", 1, 32'h3333_3333, 1'b1);

    // Randomized traffic with random downstream backpressure
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          rd = {$urandom, $urandom};
          rk = N'($urandom_range(0, 3));
          rl = 1'($urandom_range(0, 1));
          send_word(rd, rk, rl);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge aclk); #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          m_tready = 1'($urandom_range(0, 2) != 0);
          @(posedge aclk); #1;
        end
      end
    join
    m_tready = 1'b1;
    wait_idle();
    @(negedge aclk);
    chk("final_m_tvalid", {63'd0, m_tvalid}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
